kbd_event_queue: RTL and testbench
==================================

Name: kbd_event_queue

Overview:
- Sits directly downstream of the PS/2 byte receiver. Consumes one raw scan-code byte per strobe.
- Tracks the break prefix (F0), the extended prefix (E0) and modifier state (shift, ctrl, caps lock).
- Translates each key press into a 16-bit event word {flags, ascii}.
- Buffers events in a FIFO that the CPU drains through a memory-mapped read strobe.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- DECODE_FILE, "./data/scan_decode.hex", 256x8 unshifted scan-to-ASCII table.
- SHIFT_FILE, "./data/scan_decode_shift.hex", 256x8 shifted scan-to-ASCII table.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- scan_valid  in  1  one-cycle strobe: scan_byte is a new byte.
- scan_byte  in  8  raw scan byte from the receiver.
- ren  in  1  CPU read strobe; pops the head entry.
- data  out  16  head event word; 16'h0000 when empty.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, active-high) sets:
  - decoder state IDLE;
  - shift, ctrl and caps cleared;
  - FIFO pointers and count at 0;
  - ready=0, data=16'h0000, overflow=0.
- Reset mid-stream discards partial prefixes and all queued entries.
- Ignored bytes: 0x00, 0xAA, 0xEE, 0xFA, 0xFE and 0xFF are dropped in every state. State is unchanged.
- Decoder FSM (advances only on scan_valid):
  - IDLE: 0xF0 -> BRK; 0xE0 -> EXT; other byte -> make(byte, ext=0).
  - EXT: 0xF0 -> EXT_BRK; other byte -> make(byte, ext=1), then IDLE.
  - BRK: byte -> break(byte, ext=0), then IDLE.
  - EXT_BRK: byte -> break(byte, ext=1), then IDLE.
  - 0xE0 received in BRK, EXT or EXT_BRK restarts at EXT.
- Modifiers:
  - 0x12 or 0x59, ext=0: make sets shift, break clears shift.
  - 0x14, either ext value: make sets ctrl, break clears ctrl.
  - 0x58, ext=0: make toggles caps; break has no effect.
  - Modifier bytes never enqueue an event.
- Make of a non-modifier key enqueues one event:
  - u = DECODE[byte]; s = SHIFT[byte].
  - letter = (u >= 8'h61 && u <= 8'h7A).
  - Use s when (shift XOR (caps AND letter)), else u.
  - If ext=1, or the selected table value is 0: ascii field = raw byte and raw flag = 1.
- Event word layout:
  - bit 15: ext; bit 14: ctrl; bit 13: shift; bit 12: caps.
  - bit 11: raw; bit 10: break; bits 9:8 = 0; bits 7:0 = ascii or raw byte.
- Typematic repeats (repeated make without a break) each enqueue an event.
- Pipeline and latency:
  - The table lookup is registered.
  - scan_valid sampled at edge k -> entry written at edge k+1 -> ready=1 and data=entry from that edge onward, if the FIFO was empty.
  - scan_valid may be asserted every cycle.
- FIFO rules:
  - data is driven combinationally from the head entry.
  - ren with ready=1 pops at the next edge.
  - ren with ready=0 is ignored.
  - Push and pop in the same cycle: both take effect and count is unchanged. This holds at full: the pop frees the slot for the push, and nothing is dropped.
  - Push while full with no pop: the event is dropped, overflow is set, and the stored entries are unchanged.
  - overflow clears only on rst or on a pop that leaves the FIFO empty.
  - Pointers wrap modulo DEPTH.

Optional Feature:
- Macro KBD_BREAK_EVENTS_EN.
- Defined: a break of a non-modifier key enqueues an event with bit 10=1. Flags and ascii follow the make rules, using modifier state at the moment of the break.
- Undefined: break codes update modifiers only; bit 10 is always 0.

Test Plan:
- Reset, then byte 0x1C -> two edges later ready=1, data=16'h0061; ren -> ready=0, data=16'h0000.
- Bytes 0x12, 0x1C, F0 12, 0x1C -> events 16'h2041 then 16'h0061; the breaks enqueue nothing (macro undefined).
- Bytes 0x58, 0x1C, 0x12, 0x16 -> events 16'h1041 ('A'), then 16'h3021 ('!', shift with caps on a digit).
- Bytes E0 75, then E0 F0 75 -> one event 16'h8875 (ext, raw); with KBD_BREAK_EVENTS_EN a second event 16'h8C75.
- Seventeen 0x1C makes with no ren -> overflow=1, 16 entries of 16'h0061 queued. Pop all 16 -> overflow clears on the last pop.
- FIFO full, scan_valid and ren in the same cycle -> count stays 16, overflow stays 0, new entry lands at the tail.

Source files
------------

// File: rtl/kbd_event_queue.sv
// -----------------------------------------------------------------------------
// kbd_event_queue
//
// Turns the raw PS/2 set-2 scan-byte stream into 16-bit key event words and
// queues them for the CPU.
//
//   Stage 1 (scan_valid edge): prefix FSM (F0 break / E0 extended), modifier
//            tracking (shift, ctrl, caps lock) and registered table lookup.
//   Stage 2 (next edge):       shift/caps selection, raw fallback, FIFO push.
//
// Event word: [15] ext  [14] ctrl  [13] shift  [12] caps  [11] raw
//             [10] break  [9:8] 2'b00  [7:0] ascii (or raw scan byte)
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   scan_valid  one-cycle strobe, scan_byte holds a new byte
//   scan_byte   raw scan byte from the PS/2 receiver
//   ren         CPU read strobe, pops the head entry when ready=1
//   data        head event word, 16'h0000 when empty (combinational)
//   ready       FIFO non-empty
//   overflow    sticky: an event was dropped because the FIFO was full
//
// Parameters:
//   DEPTH / ADDR_W  FIFO entries (power of two, >= 2) and log2(DEPTH)
//   DECODE_FILE     unshifted scan-to-ASCII table image
//   SHIFT_FILE      shifted scan-to-ASCII table image
//   The US set-2 contents of both images are built in below as constant
//   lookup functions; an empty file name disables that table, so every key
//   that would use it is reported raw.
//
// Optional feature (macro KBD_BREAK_EVENTS_EN):
//   defined   - a break of a non-modifier key also enqueues an event, bit 10 = 1
//   undefined - break codes only update the modifiers; bit 10 is always 0
// -----------------------------------------------------------------------------
module kbd_event_queue #(
    parameter int    DEPTH       = 16,
    parameter int    ADDR_W      = 4,
    parameter string DECODE_FILE = "./data/scan_decode.hex",
    parameter string SHIFT_FILE  = "./data/scan_decode_shift.hex"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_valid,
    input  logic [7:0]  scan_byte,
    input  logic        ren,
    output logic [15:0] data,
    output logic        ready,
    output logic        overflow
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam bit DEC_EN = (DECODE_FILE != "");
    localparam bit SHF_EN = (SHIFT_FILE != "");

`ifdef KBD_BREAK_EVENTS_EN
    localparam bit BREAK_EVENTS = 1'b1;
`else
    localparam bit BREAK_EVENTS = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    // ---------------------------------------------------------------- tables
    function automatic logic [7:0] decode_unshift(input logic [7:0] code);
        case (code)
            8'h1C: decode_unshift = 8'h61; 8'h32: decode_unshift = 8'h62;
            8'h21: decode_unshift = 8'h63; 8'h23: decode_unshift = 8'h64;
            8'h24: decode_unshift = 8'h65; 8'h2B: decode_unshift = 8'h66;
            8'h34: decode_unshift = 8'h67; 8'h33: decode_unshift = 8'h68;
            8'h43: decode_unshift = 8'h69; 8'h3B: decode_unshift = 8'h6A;
            8'h42: decode_unshift = 8'h6B; 8'h4B: decode_unshift = 8'h6C;
            8'h3A: decode_unshift = 8'h6D; 8'h31: decode_unshift = 8'h6E;
            8'h44: decode_unshift = 8'h6F; 8'h4D: decode_unshift = 8'h70;
            8'h15: decode_unshift = 8'h71; 8'h2D: decode_unshift = 8'h72;
            8'h1B: decode_unshift = 8'h73; 8'h2C: decode_unshift = 8'h74;
            8'h3C: decode_unshift = 8'h75; 8'h2A: decode_unshift = 8'h76;
            8'h1D: decode_unshift = 8'h77; 8'h22: decode_unshift = 8'h78;
            8'h35: decode_unshift = 8'h79; 8'h1A: decode_unshift = 8'h7A;
            8'h45: decode_unshift = 8'h30; 8'h16: decode_unshift = 8'h31;
            8'h1E: decode_unshift = 8'h32; 8'h26: decode_unshift = 8'h33;
            8'h25: decode_unshift = 8'h34; 8'h2E: decode_unshift = 8'h35;
            8'h36: decode_unshift = 8'h36; 8'h3D: decode_unshift = 8'h37;
            8'h3E: decode_unshift = 8'h38; 8'h46: decode_unshift = 8'h39;
            8'h0E: decode_unshift = 8'h60; 8'h4E: decode_unshift = 8'h2D;
            8'h55: decode_unshift = 8'h3D; 8'h54: decode_unshift = 8'h5B;
            8'h5B: decode_unshift = 8'h5D; 8'h5D: decode_unshift = 8'h5C;
            8'h4C: decode_unshift = 8'h3B; 8'h52: decode_unshift = 8'h27;
            8'h41: decode_unshift = 8'h2C; 8'h49: decode_unshift = 8'h2E;
            8'h4A: decode_unshift = 8'h2F; 8'h29: decode_unshift = 8'h20;
            8'h5A: decode_unshift = 8'h0D; 8'h66: decode_unshift = 8'h08;
            8'h0D: decode_unshift = 8'h09; 8'h76: decode_unshift = 8'h1B;
            default: decode_unshift = 8'h00;
        endcase
    endfunction

    // Shifted table: letters are the upper-case form of the unshifted entry,
    // keys without a distinct shifted symbol repeat the unshifted entry.
    function automatic logic [7:0] decode_shift(input logic [7:0] code);
        logic [7:0] u;
        u = decode_unshift(code);
        case (code)
            8'h45: decode_shift = 8'h29; 8'h16: decode_shift = 8'h21;
            8'h1E: decode_shift = 8'h40; 8'h26: decode_shift = 8'h23;
            8'h25: decode_shift = 8'h24; 8'h2E: decode_shift = 8'h25;
            8'h36: decode_shift = 8'h5E; 8'h3D: decode_shift = 8'h26;
            8'h3E: decode_shift = 8'h2A; 8'h46: decode_shift = 8'h28;
            8'h0E: decode_shift = 8'h7E; 8'h4E: decode_shift = 8'h5F;
            8'h55: decode_shift = 8'h2B; 8'h54: decode_shift = 8'h7B;
            8'h5B: decode_shift = 8'h7D; 8'h5D: decode_shift = 8'h7C;
            8'h4C: decode_shift = 8'h3A; 8'h52: decode_shift = 8'h22;
            8'h41: decode_shift = 8'h3C; 8'h49: decode_shift = 8'h3E;
            8'h4A: decode_shift = 8'h3F;
            default: begin
                if (u >= 8'h61 && u <= 8'h7A) begin
                    decode_shift = u - 8'h20;
                end else begin
                    decode_shift = u;
                end
            end
        endcase
    endfunction

    // Receiver housekeeping bytes (self-test, ack, resend, error) never
    // reach the decoder.
    function automatic logic is_ignored(input logic [7:0] code);
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ignored = 1'b1;
            default:                                  is_ignored = 1'b0;
        endcase
    endfunction

    // ---------------------------------------------------------------- stage 1
    dec_state_t state_r, state_nxt_s;
    logic       key_make_s, key_brk_s, key_ext_s;
    logic       shift_r, ctrl_r, caps_r;
    logic       is_shift_s, is_ctrl_s, is_caps_s, is_mod_s;

    // Decoder state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Prefix FSM: next state and make/break key strobes.
    always_comb begin
        state_nxt_s = state_r;
        key_make_s  = 1'b0;
        key_brk_s   = 1'b0;
        key_ext_s   = 1'b0;
        if (scan_valid && !is_ignored(scan_byte)) begin
            case (state_r)
                ST_IDLE: begin
                    if (scan_byte == 8'hF0) begin
                        state_nxt_s = ST_BRK;
                    end else if (scan_byte == 8'hE0) begin
                        state_nxt_s = ST_EXT;
                    end else begin
                        key_make_s = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (scan_byte == 8'hE0) begin
                        state_nxt_s = ST_EXT;
                    end else if (scan_byte == 8'hF0) begin
                        state_nxt_s = ST_EXT_BRK;
                    end else begin
                        key_make_s  = 1'b1;
                        key_ext_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (scan_byte == 8'hE0) begin
                        state_nxt_s = ST_EXT;
                    end else begin
                        key_brk_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (scan_byte == 8'hE0) begin
                        state_nxt_s = ST_EXT;
                    end else begin
                        key_brk_s   = 1'b1;
                        key_ext_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Right ctrl (E0 14) is still ctrl; E0 12 / E0 59 / E0 58 are ordinary keys.
    assign is_shift_s = (scan_byte == 8'h12 || scan_byte == 8'h59) && !key_ext_s;
    assign is_ctrl_s  = (scan_byte == 8'h14);
    assign is_caps_s  = (scan_byte == 8'h58) && !key_ext_s;
    assign is_mod_s   = is_shift_s || is_ctrl_s || is_caps_s;

    // Modifier state: shift/ctrl follow make/break, caps toggles on make only.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= 1'b0;
            ctrl_r  <= 1'b0;
            caps_r  <= 1'b0;
        end else if (key_make_s) begin
            if (is_shift_s) shift_r <= 1'b1;
            if (is_ctrl_s)  ctrl_r  <= 1'b1;
            if (is_caps_s)  caps_r  <= ~caps_r;
        end else if (key_brk_s) begin
            if (is_shift_s) shift_r <= 1'b0;
            if (is_ctrl_s)  ctrl_r  <= 1'b0;
        end
    end

    logic       ev_valid_r, ev_ext_r, ev_brk_r, ev_ctrl_r, ev_shift_r, ev_caps_r;
    logic [7:0] ev_byte_r, ev_u_r, ev_s_r;

    // Event stage: valid flag is reset so a reset drops an in-flight event.
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid_r <= 1'b0;
        end else begin
            ev_valid_r <= (key_make_s || (BREAK_EVENTS && key_brk_s)) && !is_mod_s;
        end
    end

    // Event stage payload: registered table lookup plus the modifier snapshot.
    always_ff @(posedge clk) begin
        ev_ext_r   <= key_ext_s;
        ev_brk_r   <= BREAK_EVENTS && key_brk_s;
        ev_ctrl_r  <= ctrl_r;
        ev_shift_r <= shift_r;
        ev_caps_r  <= caps_r;
        ev_byte_r  <= scan_byte;
        ev_u_r     <= DEC_EN ? decode_unshift(scan_byte) : 8'h00;
        ev_s_r     <= SHF_EN ? decode_shift(scan_byte) : 8'h00;
    end

    // ---------------------------------------------------------------- stage 2
    logic       letter_s, use_s_s, raw_s;
    logic [7:0] sel_s, ascii_s;
    logic [15:0] ev_word_s;

    // Caps lock only inverts shift for letters.
    assign letter_s  = (ev_u_r >= 8'h61) && (ev_u_r <= 8'h7A);
    assign use_s_s   = ev_shift_r ^ (ev_caps_r & letter_s);
    assign sel_s     = use_s_s ? ev_s_r : ev_u_r;
    assign raw_s     = ev_ext_r || (sel_s == 8'h00);
    assign ascii_s   = raw_s ? ev_byte_r : sel_s;
    assign ev_word_s = {ev_ext_r, ev_ctrl_r, ev_shift_r, ev_caps_r,
                        raw_s, ev_brk_r, 2'b00, ascii_s};

    // ---------------------------------------------------------------- FIFO
    logic [15:0]       mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    logic              full_s, empty_s, pop_s, wr_en_s, drop_s;

    assign empty_s = (count_r == CNT_W'(0));
    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign pop_s   = ren && !empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en_s = ev_valid_r && (!full_s || pop_s);
    assign drop_s  = ev_valid_r && full_s && !pop_s;

    // Storage array; stale contents are hidden by the empty mask on data.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= ev_word_s;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            if (pop_s)   rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (pop_s && !wr_en_s && count_r == CNT_W'(1)) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign ready    = !empty_s;
    assign data     = empty_s ? 16'h0000 : mem_r[rd_ptr_r];
    assign overflow = overflow_r;

endmodule

// File: tb/tb_kbd_event_queue.sv
// -----------------------------------------------------------------------------
// tb_kbd_event_queue: directed self-checking bench for kbd_event_queue.
// All stimulus changes on the falling edge; outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_kbd_event_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_valid;
    logic [7:0]  scan_byte;
    logic        ren;
    logic [15:0] data;
    logic        ready;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    kbd_event_queue #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_valid (scan_valid),
        .scan_byte  (scan_byte),
        .ren        (ren),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_byte  = b;
        @(negedge clk);
        scan_valid = 1'b0;
        scan_byte  = 8'h00;
    endtask

    task automatic pop();
        ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic burst(input logic [7:0] b, input int n);
        scan_valid = 1'b1;
        scan_byte  = b;
        repeat (n) @(negedge clk);
        scan_valid = 1'b0;
        scan_byte  = 8'h00;
    endtask

    initial begin
        rst = 1'b1; scan_valid = 1'b0; scan_byte = 8'h00; ren = 1'b0;
        idle(3);
        rst = 1'b0;

        // Reset state
        chk("rst_ready", {15'd0, ready}, 16'h0000);
        chk("rst_data", data, 16'h0000);
        chk("rst_ovf", {15'd0, overflow}, 16'h0000);

        // Plain 'a' with two-edge latency, then pop to empty
        send(8'h1C);
        chk("lat_not_yet", {15'd0, ready}, 16'h0000);
        idle(1);
        chk("a_ready", {15'd0, ready}, 16'h0001);
        chk("a_data", data, 16'h0061);
        pop();
        chk("a_pop_ready", {15'd0, ready}, 16'h0000);
        chk("a_pop_data", data, 16'h0000);

        // Shift make, 'A', shift break, 'a'
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
        idle(1);
        chk("shift_A", data, 16'h2041);
        pop();
        chk("unshift_a", data, 16'h0061);
        pop();
        chk("shift_only2", {15'd0, ready}, 16'h0000);

        // Caps on: 'A'; then shift + digit 1 gives '!'
        send(8'h58); send(8'h1C); send(8'h12); send(8'h16);
        idle(1);
        chk("caps_A", data, 16'h1041);
        pop();
        chk("caps_shift_bang", data, 16'h3021);
        pop();
        chk("caps_only2", {15'd0, ready}, 16'h0000);
        // Release shift and switch caps off; no events from modifiers
        send(8'hF0); send(8'h12); send(8'h58);
        idle(1);
        chk("mod_no_event", {15'd0, ready}, 16'h0000);

        // Extended key with an ignored byte inside the prefix, then its break
        send(8'hE0); send(8'hAA); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        idle(1);
        chk("ext_make", data, 16'h8875);
        pop();
`ifdef KBD_BREAK_EVENTS_EN
        chk("ext_break", data, 16'h8C75);
        pop();
`endif
        chk("ext_done", {15'd0, ready}, 16'h0000);

        // Reset mid-stream drops queued entry and pending break prefix
        send(8'h1C); send(8'hF0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst_ready", {15'd0, ready}, 16'h0000);
        send(8'h1C);
        idle(1);
        chk("midrst_make", data, 16'h0061);
        pop();

        // Fill to 16 back-to-back, then overflow with two more events
        burst(8'h1C, 16);
        idle(1);
        chk("full_no_ovf", {15'd0, overflow}, 16'h0000);
        send(8'h1C);
        send(8'h32);
        idle(1);
        chk("ovf_set", {15'd0, overflow}, 16'h0001);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_entry", data, 16'h0061);
            if (i == 15) chk("ovf_sticky", {15'd0, overflow}, 16'h0001);
            pop();
        end
        chk("ovf_cleared", {15'd0, overflow}, 16'h0000);
        chk("ovf_empty", {15'd0, ready}, 16'h0000);

        // Full FIFO with push and pop on the same edge
        burst(8'h1C, 16);
        idle(1);
        scan_valid = 1'b1;
        scan_byte  = 8'h32;
        @(negedge clk);
        scan_valid = 1'b0;
        scan_byte  = 8'h00;
        ren        = 1'b1;
        @(negedge clk);
        ren        = 1'b0;
        chk("pp_ovf", {15'd0, overflow}, 16'h0000);
        for (int i = 0; i < 15; i++) begin
            chk("pp_entry", data, 16'h0061);
            pop();
        end
        chk("pp_tail", data, 16'h0062);
        pop();
        chk("pp_empty", {15'd0, ready}, 16'h0000);
        chk("pp_ovf_end", {15'd0, overflow}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
